ser_tx_arbiter: RTL and testbench
=================================

// Module: ser_tx_arbiter
// PURPOSE
// - Shares one ParToSerial serializer among NUM_REQ parallel requesters.
// - Round-robin picks a requester and captures its word.
// - Launches the serializer with a 1-cycle ParValid pulse, then tracks SerValidFlag until all WIDTH bits are out.
// - Enforces an inter-frame gap, tags the frame with its source id, and flags protocol errors.
// PARAMETERS
// - WIDTH       32  serializer word width in bits; must match the serializer's WIDTH
// - NUM_REQ     4   number of requesters, 2..16
// - GAP_CYCLES  1   idle cycles after a frame before the next grant, 0..15
// - TIMEOUT     8   max cycles from ParValid until SerValidFlag must rise, >=2
// PORTS
// - SerClock      in   1               serializer clock; all logic on posedge
// - SerResetN     in   1               asynchronous, active-low reset
// - ReqValid      in   NUM_REQ         per-requester word-available
// - ReqData       in   NUM_REQ*WIDTH   requester i word at [i*WIDTH +: WIDTH]
// - ReqReady      out  NUM_REQ         one-hot, 1-cycle accept pulse
// - ParValid      out  1               launch pulse to serializer
// - BusIn         out  WIDTH           captured word to serializer; held for the whole frame
// - SerValidFlag  in   1               serializer output-valid
// - SrcId         out  $clog2(NUM_REQ) index of the requester being sent
// - Busy          out  1               high in every state except IDLE
// - Error         out  1               sticky protocol error; cleared only by reset
// BEHAVIOUR
// - Reset (async, SerResetN=0):
//   - state=IDLE; ReqReady=0; ParValid=0; BusIn=0; SrcId=0; Busy=0; Error=0.
//   - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
// - All outputs are registered.
// - Reset mid-frame aborts immediately; the serializer is not told, and no ReqReady is reissued.
// - FSM states: IDLE, LOAD, WAIT_START, SHIFT, GAP.
// - IDLE:
//   - With any ReqValid, grant g = first set bit searching last+1, last+2, ... (mod NUM_REQ).
//   - Next edge: ReqReady[g]=1 for exactly 1 cycle; BusIn<=ReqData[g]; SrcId<=g; last<=g; go LOAD.
//   - ReqValid deasserting in the same cycle as the decision still completes the grant.
// - LOAD: ParValid=1 for exactly this cycle; cnt<=0; go WAIT_START.
// - WAIT_START:
//   - SerValidFlag=1: cnt<=1; go SHIFT.
//   - Otherwise cnt++; at cnt==TIMEOUT-1 with no flag: Error<=1; go GAP.
// - SHIFT, each cycle:
//   - SerValidFlag=1 and cnt==WIDTH: go GAP, frame done.
//   - SerValidFlag=1 and cnt<WIDTH: cnt++.
//   - SerValidFlag=0 and cnt<WIDTH: short frame; Error<=1; go GAP.
// - GAP:
//   - Stay GAP_CYCLES cycles, then go IDLE.
//   - GAP_CYCLES=0 means one-cycle pass-through to IDLE; no grant is made while in GAP.
// - Latency: ReqValid sampled in IDLE -> ReqReady +1 cycle -> ParValid +2 cycles.
// - Throughput: one word per WIDTH + GAP_CYCLES + 3 cycles, minimum, when the serializer flags the cycle after ParValid.
// - Fairness: a continuously asserted requester waits at most NUM_REQ-1 frames.
// - Counter cnt is $clog2(WIDTH+1) bits wide; comparisons are unsigned and cnt never wraps.
// - Error is sticky: a later clean frame does not clear it.
// STRUCTURE
// - Shared package ser_pkg:
//   - typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, SHIFT, GAP} ser_arb_state_t.
//   - Default constants SER_WIDTH=32 and SER_NUM_REQ=4.
// - One sub-module, rr_pick: combinational round-robin selector.
//   - Inputs: req[NUM_REQ] and last.
//   - Outputs: gnt_idx and any.
// - This top holds the FSM, counters and registers.
// - Bench instantiates ser_tx_arbiter driving a real ParToSerial instance.
// TESTING (WIDTH=32, NUM_REQ=4, GAP_CYCLES=1, TIMEOUT=8)
// - Reset check: SerResetN=0 mid-SHIFT -> all outputs 0 in the same cycle; after release, 1st grant goes to requester 0.
// - Single word: ReqValid=4'b0010, ReqData[1]=32'h1111_6666.
//   - ReqReady=4'b0010 for 1 cycle; SrcId=1; BusIn=32'h1111_6666; ParValid 1 cycle later.
//   - Serializer emits 32 bits; Busy falls 32+1+3 cycles after ReqReady; Error=0.
// - Round-robin: ReqValid=4'b1111 held for 8 frames -> grant order 0,1,2,3,0,1,2,3; exactly 1 ReqReady per frame.
// - Mid-frame arrival: ReqValid=4'b0001 then 4'b1000 during SHIFT -> 3 served after 0, only after the GAP cycle.
// - Timeout: serializer stub holds SerValidFlag=0 -> Error=1 exactly 8 cycles after ParValid; FSM returns IDLE; next request still served.
// - Short frame: stub drops SerValidFlag after 20 bits -> Error=1; Busy low 2 cycles later; Error stays 1 through a following clean frame.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and default sizing for the serializer transmit arbiter.
package ser_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, SHIFT, GAP} ser_arb_state_t;

  localparam int SER_WIDTH   = 32;
  localparam int SER_NUM_REQ = 4;

endpackage

// File: rtl/ser_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: nearest requester after 'last', wrapping.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  logic [IDX_W:0] sum;

  // Scan from the farthest slot to the nearest so the nearest hit wins.
  always_comb begin
    gnt_idx = '0;
    sum     = '0;
    any     = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum = {1'b0, last} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      if (req[sum[IDX_W-1:0]]) begin
        gnt_idx = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ser_tx_arbiter.sv
// Shares one ParToSerial serializer among NUM_REQ requesters: round-robin grant,
// launch pulse, bit tracking against SerValidFlag, inter-frame gap, sticky Error.
module ser_tx_arbiter
  import ser_pkg::*;
#(
  parameter  int WIDTH      = SER_WIDTH,
  parameter  int NUM_REQ    = SER_NUM_REQ,
  parameter  int GAP_CYCLES = 1,
  parameter  int TIMEOUT    = 8,
  localparam int IDX_W      = $clog2(NUM_REQ),
  localparam int CNT_W      = $clog2(WIDTH+1)
) (
  input  logic                     SerClock,
  input  logic                     SerResetN,
  input  logic [NUM_REQ-1:0]       ReqValid,
  input  logic [NUM_REQ*WIDTH-1:0] ReqData,
  output logic [NUM_REQ-1:0]       ReqReady,
  output logic                     ParValid,
  output logic [WIDTH-1:0]         BusIn,
  input  logic                     SerValidFlag,
  output logic [IDX_W-1:0]         SrcId,
  output logic                     Busy,
  output logic                     Error
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       GAP_LAST = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  ser_arb_state_t   state;
  logic [IDX_W-1:0] last;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       gapCnt;
  logic [IDX_W-1:0] gntIdx;
  logic             gntAny;
  logic [WIDTH-1:0] reqWord [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
      assign reqWord[gi] = ReqData[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (ReqValid),
    .last   (last),
    .gnt_idx(gntIdx),
    .any    (gntAny)
  );

  always_ff @(posedge SerClock or negedge SerResetN) begin
    if (!SerResetN) begin
      state    <= IDLE;
      ReqReady <= '0;
      ParValid <= 1'b0;
      BusIn    <= '0;
      SrcId    <= '0;
      Busy     <= 1'b0;
      Error    <= 1'b0;
      last     <= IDX_W'(NUM_REQ - 1);
      cnt      <= '0;
      gapCnt   <= '0;
    end else begin
      ReqReady <= '0;
      ParValid <= 1'b0;
      case (state)
        IDLE: begin
          if (gntAny) begin
            ReqReady <= NUM_REQ'(1) << gntIdx;
            BusIn    <= reqWord[gntIdx];
            SrcId    <= gntIdx;
            last     <= gntIdx;
            Busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          ParValid <= 1'b1;
          cnt      <= '0;
          state    <= WAIT_START;
        end
        WAIT_START: begin
          if (SerValidFlag) begin
            cnt   <= CNT_W'(1);
            state <= SHIFT;
          end else if (cnt == CNT_TO) begin
            Error  <= 1'b1;
            gapCnt <= '0;
            state  <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          // All WIDTH bits seen: the flag is already low on this trailing cycle.
          if (cnt == CNT_FULL) begin
            gapCnt <= '0;
            state  <= GAP;
          end else if (SerValidFlag) begin
            cnt <= cnt + 1'b1;
          end else begin
            Error  <= 1'b1;
            gapCnt <= '0;
            state  <= GAP;
          end
        end
        GAP: begin
          if (gapCnt == GAP_LAST) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gapCnt <= gapCnt + 1'b1;
          end
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_tx_arbiter.sv
// Bench: arbiter driving a behavioural ParToSerial model, with requester queues,
// a frame scoreboard, a vector table and hand-written corner-case sequences.
module tb_ser_tx_arbiter;

  logic         SerClock = 1'b0;
  logic         SerResetN = 1'b0;
  logic [3:0]   ReqValid = '0;
  logic [127:0] ReqData = '0;
  logic [3:0]   ReqReady;
  logic         ParValid;
  logic [31:0]  BusIn;
  logic         SerValidFlag = 1'b0;
  logic [1:0]   SrcId;
  logic         Busy;
  logic         Error;

  int checks = 0;
  int errors = 0;

  ser_tx_arbiter #(.WIDTH(32), .NUM_REQ(4), .GAP_CYCLES(1), .TIMEOUT(8)) dut (
    .SerClock    (SerClock),
    .SerResetN   (SerResetN),
    .ReqValid    (ReqValid),
    .ReqData     (ReqData),
    .ReqReady    (ReqReady),
    .ParValid    (ParValid),
    .BusIn       (BusIn),
    .SerValidFlag(SerValidFlag),
    .SrcId       (SrcId),
    .Busy        (Busy),
    .Error       (Error)
  );

  always #5 SerClock = ~SerClock;

  // ParToSerial model, MSB first; mode 0 normal, 1 never flags, 2 stops after 20 bits.
  int          serMode = 0;
  int          serLeft = 0;
  logic [31:0] serSh = '0;
  always @(posedge SerClock) begin
    if (ParValid && serMode != 1) begin
      serSh        <= BusIn;
      serLeft      <= (serMode == 2) ? 20 : 32;
      SerValidFlag <= 1'b1;
    end else if (serLeft > 1) begin
      serSh   <= serSh << 1;
      serLeft <= serLeft - 1;
    end else begin
      serLeft      <= 0;
      SerValidFlag <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Requesters: ReqValid follows queue occupancy, a word is consumed on ReqReady.
  logic [31:0] reqQ [4][$];
  always @(negedge SerClock) begin
    for (int i = 0; i < 4; i++) begin
      if (ReqReady[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
      ReqValid[i] = (reqQ[i].size() > 0);
      ReqData[i*32 +: 32] = (reqQ[i].size() > 0) ? reqQ[i][0] : 32'h0;
    end
  end

  // Scoreboard of frames expected on the serial line.
  typedef struct packed { logic [1:0] src; logic [31:0] data; } sb_t;
  sb_t         sbQ[$];
  bit          collectEn = 1'b1;
  int          colBits = 0;
  logic [31:0] colWord = '0;
  always @(negedge SerClock) begin
    if (SerValidFlag) begin
      colWord = {colWord[30:0], serSh[31]};
      colBits++;
      if (colBits == 32) begin
        colBits = 0;
        if (collectEn) begin
          $display("frame src=%0d data=%h", SrcId, colWord);
          if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame actual=%h expected=none", colWord);
          end else begin
            sb_t e;
            e = sbQ.pop_front();
            check("frame_data", colWord, e.data);
            check("frame_src", {30'b0, SrcId}, {30'b0, e.src});
          end
        end
      end
    end else begin
      colBits = 0;
    end
  end

  task automatic tick();
    @(posedge SerClock);
    #1;
  endtask

  task automatic waitReady();
    int n = 0;
    while (ReqReady == 4'b0 && n < 80) begin
      tick();
      n++;
    end
    if (ReqReady == 4'b0) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=none expected=grant");
    end
  endtask

  // Returns the number of extra ReqReady pulses seen before Busy falls.
  task automatic waitIdle(output int extra);
    int n = 0;
    extra = 0;
    while (Busy && n < 100) begin
      tick();
      n++;
      if (ReqReady != 4'b0 && Busy) extra++;
    end
    if (Busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  task automatic pushReq(input int idx, input logic [31:0] data, input bit expectFrame);
    sb_t e;
    reqQ[idx].push_back(data);
    if (expectFrame) begin
      e.src  = 2'(idx);
      e.data = data;
      sbQ.push_back(e);
    end
  endtask

  task automatic pulseReset();
    SerResetN = 1'b0;
    repeat (3) tick();
    SerResetN = 1'b1;
    tick();
  endtask

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [3:0]  expReady;
    logic [1:0]  expSrc;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int n;
    int extra;

    vecs[0] = '{idx: 0, data: 32'h0000_0000, expReady: 4'b0001, expSrc: 2'd0};
    vecs[1] = '{idx: 3, data: 32'hFFFF_FFFF, expReady: 4'b1000, expSrc: 2'd3};
    vecs[2] = '{idx: 2, data: 32'hA5A5_5A5A, expReady: 4'b0100, expSrc: 2'd2};
    vecs[3] = '{idx: 1, data: 32'h8000_0001, expReady: 4'b0010, expSrc: 2'd1};

    // Reset state
    #5;
    check("rst_ready", {28'b0, ReqReady}, 32'h0);
    check("rst_parvalid", {31'b0, ParValid}, 32'h0);
    check("rst_busin", BusIn, 32'h0);
    check("rst_busy", {31'b0, Busy}, 32'h0);
    check("rst_error", {31'b0, Error}, 32'h0);
    tick();
    SerResetN = 1'b1;
    tick();

    // Single word from requester 1
    pushReq(1, 32'h1111_6666, 1'b1);
    waitReady();
    check("single_ready", {28'b0, ReqReady}, 32'h2);
    check("single_src", {30'b0, SrcId}, 32'h1);
    check("single_busin", BusIn, 32'h1111_6666);
    check("single_parvalid_early", {31'b0, ParValid}, 32'h0);
    tick();
    check("single_parvalid", {31'b0, ParValid}, 32'h1);
    check("single_ready_pulse", {28'b0, ReqReady}, 32'h0);
    n = 1;
    while (Busy && n < 100) begin
      tick();
      n++;
    end
    check("single_busy_fall", n, 36);
    check("single_error", {31'b0, Error}, 32'h0);

    // Vector table: one requester at a time
    foreach (vecs[v]) begin
      tick();
      pushReq(vecs[v].idx, vecs[v].data, 1'b1);
      waitReady();
      check("vec_ready", {28'b0, ReqReady}, {28'b0, vecs[v].expReady});
      check("vec_src", {30'b0, SrcId}, {30'b0, vecs[v].expSrc});
      check("vec_busin", BusIn, vecs[v].data);
      waitIdle(extra);
      check("vec_error", {31'b0, Error}, 32'h0);
    end

    // Reset in the middle of SHIFT
    tick();
    pushReq(2, 32'hDEAD_BEEF, 1'b0);
    waitReady();
    collectEn = 1'b0;
    repeat (10) tick();
    check("midrst_busy_before", {31'b0, Busy}, 32'h1);
    SerResetN = 1'b0;
    #1;
    check("midrst_ready", {28'b0, ReqReady}, 32'h0);
    check("midrst_parvalid", {31'b0, ParValid}, 32'h0);
    check("midrst_busin", BusIn, 32'h0);
    check("midrst_src", {30'b0, SrcId}, 32'h0);
    check("midrst_busy", {31'b0, Busy}, 32'h0);
    check("midrst_error", {31'b0, Error}, 32'h0);
    repeat (40) tick();
    collectEn = 1'b1;
    SerResetN = 1'b1;
    tick();

    // Round robin: all four requesters hold two words each
    for (int r = 0; r < 8; r++) begin
      pushReq(r % 4, {8'hC0 + 8'(r), 24'h00_5A3C ^ 24'(r * 24'h010203)}, 1'b1);
    end
    for (int r = 0; r < 8; r++) begin
      waitReady();
      check("rr_src", {30'b0, SrcId}, r % 4);
      check("rr_ready", {28'b0, ReqReady}, 32'h1 << (r % 4));
      waitIdle(extra);
      check("rr_one_ready", extra, 0);
    end

    // Requester 3 arrives while requester 0 is shifting
    tick();
    pushReq(0, 32'h0F0F_0F0F, 1'b1);
    waitReady();
    check("mid_first_src", {30'b0, SrcId}, 32'h0);
    repeat (10) tick();
    pushReq(3, 32'h3333_CCCC, 1'b1);
    n = 10;
    while (ReqReady == 4'b0 && n < 100) begin
      tick();
      n++;
    end
    check("mid_second_ready", {28'b0, ReqReady}, 32'h8);
    check("mid_second_delay", n, 37);
    waitIdle(extra);

    // Timeout: serializer never raises its flag
    serMode = 1;
    tick();
    pushReq(2, 32'h2222_2222, 1'b0);
    waitReady();
    tick();
    check("to_parvalid", {31'b0, ParValid}, 32'h1);
    n = 0;
    while (!Error && n < 30) begin
      tick();
      n++;
    end
    check("to_error_delay", n, 8);
    waitIdle(extra);
    serMode = 0;
    pushReq(1, 32'h7777_1234, 1'b1);
    waitReady();
    check("to_next_src", {30'b0, SrcId}, 32'h1);
    waitIdle(extra);
    check("to_error_sticky", {31'b0, Error}, 32'h1);

    // Short frame: serializer stops after 20 bits
    pulseReset();
    check("sf_error_cleared", {31'b0, Error}, 32'h0);
    serMode = 2;
    pushReq(0, 32'h1234_5678, 1'b0);
    waitReady();
    n = 0;
    while (!SerValidFlag && n < 20) begin
      tick();
      n++;
    end
    n = 0;
    while (SerValidFlag && n < 40) begin
      tick();
      n++;
    end
    check("sf_bits", n, 20);
    check("sf_error_d0", {31'b0, Error}, 32'h0);
    tick();
    check("sf_error_d1", {31'b0, Error}, 32'h1);
    check("sf_busy_d1", {31'b0, Busy}, 32'h1);
    tick();
    check("sf_busy_d2", {31'b0, Busy}, 32'h0);
    serMode = 0;
    pushReq(3, 32'hCAFE_F00D, 1'b1);
    waitReady();
    waitIdle(extra);
    repeat (3) tick();
    check("sf_error_sticky", {31'b0, Error}, 32'h1);
    check("sb_empty", sbQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
